// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder: FSM states,
// operation encoding and default geometry/latency constants.
package dmem_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_DONE = 2'd2
    } dm_state_t;

    localparam logic OP_LD = 1'b0;
    localparam logic OP_ST = 1'b1;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous WIDTH x DEPTH RAM with registered read data.
// Deliberately unreset so synthesis can map it onto block RAM.
module dmem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port and read-before-write registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one load/store in flight, fixed latency,
// one-cycle Ready pulse. Optional misalignment trap: DMEM_MISALIGN_CHECK_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int AW      = $clog2(DEPTH),
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Read,
    input  logic             Write,
    input  logic [31:0]      Addr,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    output logic             Ready,
    output logic             Busy,
    output logic             Err
);

    dm_state_t        state_r;
    logic [3:0]       cnt_r;
    logic [AW-1:0]    idx_r;
    logic [WIDTH-1:0] wdata_r;
    logic             op_r;
    logic             conflict_r;
    logic [AW-1:0]    ram_addr_s;
    logic             ram_we_s;
    logic             bad_s;
    logic [WIDTH-1:0] ram_rdata_s;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic [1:0] lo_r;
    logic       addr_unused_s;
    assign addr_unused_s = ^Addr[31:AW+2];
`else
    logic       addr_unused_s;
    assign addr_unused_s = ^{Addr[31:AW+2], Addr[1:0]};
`endif

    // Illegal-request classification of the latched request
    always_comb begin
        bad_s = conflict_r;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (lo_r != 2'b00) begin
            bad_s = 1'b1;
        end else begin
            bad_s = conflict_r;
        end
`endif
    end

    // RAM address tracks the live bus in IDLE so read data is ready by the final WAIT edge
    always_comb begin
        ram_addr_s = Addr[AW+1:2];
        if (state_r == DM_IDLE) begin
            ram_addr_s = Addr[AW+1:2];
        end else begin
            ram_addr_s = idx_r;
        end
        ram_we_s = (state_r == DM_WAIT) && (cnt_r == 4'd0) && (op_r == OP_ST)
                   && !bad_s && !rst;
    end

    dmem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // Request FSM, latency counter, request latches and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DM_IDLE;
            cnt_r      <= 4'd0;
            idx_r      <= {AW{1'b0}};
            wdata_r    <= {WIDTH{1'b0}};
            op_r       <= OP_LD;
            conflict_r <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
            lo_r       <= 2'b00;
`endif
            ReadData   <= {WIDTH{1'b0}};
            Ready      <= 1'b0;
            Busy       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            case (state_r)
                DM_IDLE: begin
                    Ready <= 1'b0;
                    Err   <= 1'b0;
                    if (Read || Write) begin
                        idx_r      <= Addr[AW+1:2];
                        wdata_r    <= WriteData;
                        op_r       <= Write ? OP_ST : OP_LD;
                        conflict_r <= Read && Write;
`ifdef DMEM_MISALIGN_CHECK_EN
                        lo_r       <= Addr[1:0];
`endif
                        cnt_r      <= 4'(LATENCY - 1);
                        Busy       <= 1'b1;
                        state_r    <= DM_WAIT;
                    end
                end
                DM_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= DM_DONE;
                        Ready   <= 1'b1;
                        Busy    <= 1'b0;
                        Err     <= bad_s;
                        if (bad_s) begin
                            ReadData <= {WIDTH{1'b0}};
                        end else if (op_r == OP_LD) begin
                            ReadData <= ram_rdata_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                DM_DONE: begin
                    Ready   <= 1'b0;
                    Err     <= 1'b0;
                    state_r <= DM_IDLE;
                end
                default: begin
                    Ready   <= 1'b0;
                    Busy    <= 1'b0;
                    Err     <= 1'b0;
                    state_r <= DM_IDLE;
                end
            endcase
        end
    end

endmodule
